// File: rtl/systolic_result_drain.sv
// ---------------------------------------------------------------------------
// systolic_result_drain
//
// Result drain stage behind the 4x4 systolic array controller. When the
// controller raises done, every PE accumulator is copied into a local
// snapshot buffer. The snapshot is then streamed out in row-major order over
// a valid/ready interface. After the last element is accepted, the block
// pulses acc_clear (to zero the PE accumulators) and drain_done for one
// cycle, then re-arms for the next matrix.
//
// Each element is narrowed from ACC_W to OUT_W bits. With SATURATE=1 the
// value is clipped to the signed OUT_W range; with SATURATE=0 only the low
// OUT_W bits are kept. OUT_W must not exceed ACC_W.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   done        in   level from controller, high when the array result is final
//   pe_acc      in   flat accumulator bus, element (r,c) at
//                    [(r*COL_NUM+c)*ACC_W +: ACC_W]
//   out_ready   in   downstream accepts the current element
//   out_valid   out  out_data/out_row/out_col/out_sat/out_last are valid
//   out_data    out  converted signed result
//   out_row     out  row index of the current element
//   out_col     out  column index of the current element
//   out_sat     out  current element was clipped
//   out_last    out  current element is the last one, (ROW_NUM-1, COL_NUM-1)
//   busy        out  drain in progress (STREAM or FINISH)
//   acc_clear   out  one-cycle pulse to zero the PE accumulators
//   drain_done  out  one-cycle pulse at the end of a drain
//
// States
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | waiting for a rising edge on done; the snapshot is taken then
//   S_STREAM | presenting buffer[index]; the index advances on each handshake
//   S_FINISH | single cycle: acc_clear and drain_done pulse, then back to idle
// ---------------------------------------------------------------------------
module systolic_result_drain #(
    parameter int ROW_NUM  = 4,
    parameter int COL_NUM  = 4,
    parameter int ACC_W    = 20,
    parameter int OUT_W    = 16,
    parameter int SATURATE = 1
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        done,
    input  logic [ROW_NUM*COL_NUM*ACC_W-1:0]            pe_acc,
    input  logic                                        out_ready,
    output logic                                        out_valid,
    output logic [OUT_W-1:0]                            out_data,
    output logic [((ROW_NUM > 1) ? $clog2(ROW_NUM) : 1)-1:0] out_row,
    output logic [((COL_NUM > 1) ? $clog2(COL_NUM) : 1)-1:0] out_col,
    output logic                                        out_sat,
    output logic                                        out_last,
    output logic                                        busy,
    output logic                                        acc_clear,
    output logic                                        drain_done
);

    localparam int N     = ROW_NUM * COL_NUM;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int ROW_W = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
    localparam int COL_W = (COL_NUM > 1) ? $clog2(COL_NUM) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [OUT_W-1:0] OUT_MAX  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN  = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic [N*ACC_W-1:0]     buf_q;
    logic                   done_q;
    logic                   load;
    logic                   rise;

    assign rise = done & ~done_q;

    // -----------------------------------------------------------------------
    // State, index, edge detector and snapshot registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            index_q <= '0;
            buf_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            // The edge detector runs in every state, so a done level held
            // across a drain never looks like a fresh rise once idle again.
            done_q  <= done;
            if (load) begin
                buf_q <= pe_acc;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and control outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        load       = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        acc_clear  = 1'b0;
        drain_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    load    = 1'b1;
                    index_d = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    if (index_q == LAST_IDX) begin
                        state_d = S_FINISH;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                    end
                end
            end
            S_FINISH: begin
                busy       = 1'b1;
                acc_clear  = 1'b1;
                drain_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Element select and width conversion
    // -----------------------------------------------------------------------
    logic [ACC_W-1:0]       acc_sel;
    logic [ACC_W-OUT_W:0]   acc_upper;
    logic                   ovf;
    logic [OUT_W-1:0]       conv_data;
    logic [31:0]            idx32;
    logic [31:0]            row32;
    logic [31:0]            col32;

    assign acc_sel   = buf_q[index_q*ACC_W +: ACC_W];

    // The value fits in OUT_W signed bits exactly when the sign bit of the
    // narrow result and every bit above it agree. With OUT_W == ACC_W this
    // slice is just the sign bit, so ovf is always 0 and data passes through.
    assign acc_upper = acc_sel[ACC_W-1:OUT_W-1];
    assign ovf       = (SATURATE != 0) && !((&acc_upper) || !(|acc_upper));

    always_comb begin
        conv_data = acc_sel[OUT_W-1:0];
        if (ovf) begin
            conv_data = acc_sel[ACC_W-1] ? OUT_MIN : OUT_MAX;
        end
    end

    // Index arithmetic is done at 32 bits so that dividing by COL_NUM never
    // truncates the divisor when COL_NUM equals N.
    assign idx32 = 32'(index_q);
    assign row32 = idx32 / 32'(COL_NUM);
    assign col32 = idx32 % 32'(COL_NUM);

    // Data fields are forced to zero whenever nothing is being presented, so
    // the bus is quiet in IDLE/FINISH and immediately after reset.
    assign out_data = out_valid ? conv_data         : '0;
    assign out_row  = out_valid ? row32[ROW_W-1:0]  : '0;
    assign out_col  = out_valid ? col32[COL_W-1:0]  : '0;
    assign out_sat  = out_valid & ovf;
    assign out_last = out_valid & (index_q == LAST_IDX);

endmodule

// File: tb/tb_systolic_result_drain.sv
module tb_systolic_result_drain;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int AW = 20;
    localparam int OW = 16;
    localparam int N  = R * C;

    logic              clk;
    logic              rst_n;
    logic              done;
    logic [N*AW-1:0]   pe_acc;
    logic              out_ready;

    logic              v, sat, last, busy, clr, dd;
    logic [OW-1:0]     d;
    logic [1:0]        row, col;

    logic              w_v, w_sat, w_last, w_busy, w_clr, w_dd;
    logic [OW-1:0]     w_d;
    logic [1:0]        w_row, w_col;

    int total = 0;
    int bad   = 0;

    logic signed [AW-1:0] vals [N];

    systolic_result_drain #(
        .ROW_NUM(R), .COL_NUM(C), .ACC_W(AW), .OUT_W(OW), .SATURATE(1)
    ) u_sat (
        .clk(clk), .rst_n(rst_n), .done(done), .pe_acc(pe_acc),
        .out_ready(out_ready), .out_valid(v), .out_data(d),
        .out_row(row), .out_col(col), .out_sat(sat), .out_last(last),
        .busy(busy), .acc_clear(clr), .drain_done(dd)
    );

    systolic_result_drain #(
        .ROW_NUM(R), .COL_NUM(C), .ACC_W(AW), .OUT_W(OW), .SATURATE(0)
    ) u_wrap (
        .clk(clk), .rst_n(rst_n), .done(done), .pe_acc(pe_acc),
        .out_ready(out_ready), .out_valid(w_v), .out_data(w_d),
        .out_row(w_row), .out_col(w_col), .out_sat(w_sat), .out_last(w_last),
        .busy(w_busy), .acc_clear(w_clr), .drain_done(w_dd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pack_vals();
        for (int i = 0; i < N; i++) pe_acc[i*AW +: AW] = vals[i];
    endtask

    task automatic set_linear(input int base);
        for (int i = 0; i < N; i++) vals[i] = AW'(base + 10*(i/C) + (i%C));
        pack_vals();
    endtask

    // done low -> high at a negedge; returns at the negedge after capture
    task automatic trigger();
        done = 1'b0;
        @(negedge clk);
        done = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b1; done = 1'b0; out_ready = 1'b0; pe_acc = '0;
        #2 rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        total++;
        if ({v, d, row, col, sat, last, busy, clr, dd} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %b required 0",
                     {v, d, row, col, sat, last, busy, clr, dd});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({v, busy, clr, dd} !== 4'b0) begin
            bad++;
            $display("FAIL reset_release_idle: got %b required 0000", {v, busy, clr, dd});
        end
    endtask

    task automatic test_basic();
        int busy_cnt = 0;
        logic [OW-1:0] e;
        set_linear(0);
        out_ready = 1'b1;
        trigger();
        done = 1'b0;
        for (int k = 0; k < N; k++) begin
            e = OW'(10*(k/C) + (k%C));
            total++;
            if ({v, d, row, col, last, clr, dd} !== {1'b1, e, 2'(k/C), 2'(k%C), (k == N-1), 2'b00}) begin
                bad++;
                $display("FAIL basic_beat%0d: got v=%b d=%0d r=%0d c=%0d last=%b clr=%b dd=%b required d=%0d r=%0d c=%0d last=%b",
                         k, v, d, row, col, last, clr, dd, e, k/C, k%C, (k == N-1));
            end
            if (busy) busy_cnt++;
            @(negedge clk);
        end
        total++;
        if ({v, clr, dd} !== 3'b011) begin
            bad++;
            $display("FAIL basic_finish: got v=%b clr=%b dd=%b required 0 1 1", v, clr, dd);
        end
        if (busy) busy_cnt++;
        @(negedge clk);
        total++;
        if ({v, clr, dd, busy} !== 4'b0) begin
            bad++;
            $display("FAIL basic_after_finish: got v=%b clr=%b dd=%b busy=%b required 0", v, clr, dd, busy);
        end
        total++;
        if (busy_cnt != N + 1) begin
            bad++;
            $display("FAIL basic_busy_len: got %0d required %0d", busy_cnt, N + 1);
        end
    endtask

    task automatic test_backpressure();
        int k = 0;
        int cyc = 0;
        bit seen_dd = 0;
        bit stalled = 0;
        logic [OW+3:0] prev = '0;
        logic [OW-1:0] e;
        logic [3:0] pat = 4'b1001;   // pat[cyc%4]: 1,0,0,1
        set_linear(100);
        out_ready = 1'b1;
        trigger();
        done = 1'b0;
        while (!seen_dd && cyc < 200) begin
            if (dd) seen_dd = 1;
            if (v) begin
                if (stalled) begin
                    total++;
                    if ({d, row, col} !== prev) begin
                        bad++;
                        $display("FAIL bp_stable_cyc%0d: got %h required %h", cyc, {d, row, col}, prev);
                    end
                end
                e = OW'(100 + 10*(k/C) + (k%C));
                total++;
                if ({d, row, col, last} !== {e, 2'(k/C), 2'(k%C), (k == N-1)}) begin
                    bad++;
                    $display("FAIL bp_beat%0d: got d=%0d r=%0d c=%0d last=%b required d=%0d r=%0d c=%0d",
                             k, d, row, col, last, e, k/C, k%C);
                end
            end
            out_ready = pat[cyc % 4];
            stalled = v && !out_ready;
            prev = {d, row, col};
            if (v && out_ready) k++;
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b1;
        total++;
        if (!seen_dd || k != N) begin
            bad++;
            $display("FAIL bp_count: got beats=%0d drain_done=%b required beats=%0d drain_done=1", k, seen_dd, N);
        end
    endtask

    task automatic test_saturation();
        logic [OW-1:0] es [5] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'hFFFF};
        logic          ss [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [OW-1:0] ew [5] = '{16'h9C40, 16'h63C0, 16'h7FFF, 16'h8000, 16'hFFFF};
        int cyc = 0;
        for (int i = 0; i < N; i++) vals[i] = '0;
        vals[0] = AW'(40000);
        vals[1] = AW'(-40000);
        vals[2] = AW'(32767);
        vals[3] = AW'(-32768);
        vals[4] = AW'(-1);
        pack_vals();
        out_ready = 1'b1;
        trigger();
        done = 1'b0;
        for (int k = 0; k < 5; k++) begin
            total++;
            if ({v, d, sat} !== {1'b1, es[k], ss[k]}) begin
                bad++;
                $display("FAIL sat_beat%0d: got v=%b d=%h sat=%b required d=%h sat=%b", k, v, d, sat, es[k], ss[k]);
            end
            total++;
            if ({w_v, w_d, w_sat} !== {1'b1, ew[k], 1'b0}) begin
                bad++;
                $display("FAIL wrap_beat%0d: got v=%b d=%h sat=%b required d=%h sat=0", k, w_v, w_d, w_sat, ew[k]);
            end
            @(negedge clk);
        end
        while (!dd && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (!dd) begin
            bad++;
            $display("FAIL sat_drain_end: got drain_done=0 required 1 within 50 cycles");
        end
        @(negedge clk);
    endtask

    // Counts drains and beats over a fixed window, checking each beat.
    task automatic test_retrigger();
        int k, ddcnt;
        logic [OW-1:0] e;
        out_ready = 1'b1;
        // A: done held high for the whole window
        set_linear(200);
        trigger();
        k = 0; ddcnt = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (dd) ddcnt++;
            if (v) begin
                e = OW'(200 + 10*(k/C) + (k%C));
                total++;
                if (d !== e) begin
                    bad++;
                    $display("FAIL retrig_a_beat%0d: got %0d required %0d", k, d, e);
                end
                k++;
            end
            @(negedge clk);
        end
        total++;
        if (ddcnt != 1 || k != N) begin
            bad++;
            $display("FAIL retrig_hold: got drains=%0d beats=%0d required 1 %0d", ddcnt, k, N);
        end
        // B: toggle after drain_done re-arms with fresh data; toggle mid-stream ignored
        set_linear(300);
        trigger();
        k = 0; ddcnt = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc == 5) done = 1'b0;
            if (cyc == 6) done = 1'b1;
            if (dd) ddcnt++;
            if (v) begin
                e = OW'(300 + 10*(k/C) + (k%C));
                total++;
                if (d !== e) begin
                    bad++;
                    $display("FAIL retrig_b_beat%0d: got %0d required %0d", k, d, e);
                end
                k++;
            end
            @(negedge clk);
        end
        total++;
        if (ddcnt != 1 || k != N) begin
            bad++;
            $display("FAIL retrig_midstream: got drains=%0d beats=%0d required 1 %0d", ddcnt, k, N);
        end
        done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_snapshot();
        int k = 0;
        int cyc = 0;
        logic [OW-1:0] e;
        set_linear(400);
        out_ready = 1'b1;
        trigger();
        done = 1'b0;
        while (!dd && cyc < 60) begin
            if (v) begin
                e = OW'(400 + 10*(k/C) + (k%C));
                total++;
                if (d !== e) begin
                    bad++;
                    $display("FAIL snap_beat%0d: got %0d required %0d", k, d, e);
                end
                k++;
            end
            for (int i = 0; i < N; i++) pe_acc[i*AW +: AW] = AW'($urandom);
            @(negedge clk);
            cyc++;
        end
        total++;
        if (!dd || k != N) begin
            bad++;
            $display("FAIL snap_count: got beats=%0d drain_done=%b required %0d 1", k, dd, N);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int flags = 0;
        int cyc = 0;
        logic [OW-1:0] e;
        set_linear(500);
        out_ready = 1'b1;
        trigger();
        done = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clk);
        total++;
        if ({v, row, col} !== {1'b1, 2'd1, 2'd3}) begin
            bad++;
            $display("FAIL rmid_beat7: got v=%b r=%0d c=%0d required 1 1 3", v, row, col);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({v, d, row, col, sat, last, busy, clr, dd} !== '0) begin
            bad++;
            $display("FAIL rmid_outputs: got %b required 0", {v, d, row, col, sat, last, busy, clr, dd});
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (clr || dd) flags++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (clr || dd || v) flags++;
        end
        total++;
        if (flags != 0) begin
            bad++;
            $display("FAIL rmid_no_finish: got %0d strobe cycles required 0", flags);
        end
        set_linear(600);
        trigger();
        done = 1'b0;
        while (!dd && cyc < 60) begin
            if (v) begin
                e = OW'(600 + 10*(k/C) + (k%C));
                total++;
                if ({d, row, col} !== {e, 2'(k/C), 2'(k%C)}) begin
                    bad++;
                    $display("FAIL rmid_redrain%0d: got d=%0d r=%0d c=%0d required d=%0d r=%0d c=%0d",
                             k, d, row, col, e, k/C, k%C);
                end
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        total++;
        if (!dd || k != N) begin
            bad++;
            $display("FAIL rmid_redrain_count: got beats=%0d drain_done=%b required %0d 1", k, dd, N);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_retrigger();
        test_snapshot();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Downstream stage of the 4x4 systolic array controller.
- When the controller raises done, the block snapshots all PE accumulators and streams them out in row-major order over a valid/ready interface.
- Each result is converted to the output width, with optional signed saturation.
- After the last element is accepted, it pulses a clear to the PE accumulators and a completion strobe, then re-arms for the next matrix.

Parameters:
- ROW_NUM, 4, array rows.
- COL_NUM, 4, array columns.
- ACC_W, 20, signed PE accumulator width.
- OUT_W, 16, signed output width; OUT_W <= ACC_W is required.
- SATURATE, 1, 1 = signed saturate to OUT_W; 0 = keep low OUT_W bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- done  in  1  level from controller; high when the array result is final.
- pe_acc  in  ROW_NUM*COL_NUM*ACC_W  flat accumulator bus; element (r,c) at bits [(r*COL_NUM+c)*ACC_W +: ACC_W].
- out_ready  in  1  downstream accepts the current element.
- out_valid  out  1  out_data, out_row, out_col, out_sat and out_last are valid.
- out_data  out  OUT_W  converted signed result.
- out_row  out  max(1,$clog2(ROW_NUM))  row index of the current element.
- out_col  out  max(1,$clog2(COL_NUM))  column index of the current element.
- out_sat  out  1  current element was clipped (always 0 when SATURATE=0).
- out_last  out  1  current element is (ROW_NUM-1, COL_NUM-1).
- busy  out  1  high in STREAM and FINISH.
- acc_clear  out  1  one-cycle pulse to zero the PE accumulators.
- drain_done  out  1  one-cycle pulse at end of drain.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all outputs 0.
  - Index counter 0, done_d 0, snapshot buffer 0.
  - Reset mid-stream abandons the drain; no acc_clear and no drain_done are issued.
- Trigger: rise = done & ~done_d. done_d is registered every cycle in every state.
- States:
  - IDLE: on rise, at that clock edge buffer <= pe_acc, index <= 0, state <= STREAM. Otherwise hold.
  - STREAM: out_valid=1; outputs are driven from buffer[index]. Handshake = out_valid & out_ready.
    - On handshake with index < N-1 (N=ROW_NUM*COL_NUM): index <= index+1.
    - On handshake with index == N-1: state <= FINISH.
    - Without a handshake, all out_* fields hold stable.
  - FINISH: exactly one cycle. acc_clear=1, drain_done=1, out_valid=0. Next state IDLE.
- Latency:
  - out_valid rises on the cycle after the edge that samples the rise.
  - With out_ready tied high, N consecutive beats follow.
  - FINISH occurs the cycle after the last beat, so the total is N+1 cycles after capture.
- Rises while busy are ignored and not queued. done held high across a whole drain does not retrigger; re-arm needs done low for at least 1 cycle, then high.
- pe_acc changes after capture do not affect streamed data.
- out_row = index / COL_NUM; out_col = index % COL_NUM; out_last = (index == N-1) & out_valid.
- Conversion with MAX = 2^(OUT_W-1)-1 and MIN = -2^(OUT_W-1):
  - SATURATE=1: acc > MAX → MAX, out_sat=1; acc < MIN → MIN, out_sat=1; else sign-truncate, out_sat=0.
  - SATURATE=0: low OUT_W bits, out_sat=0.
  - OUT_W == ACC_W: pass-through, out_sat=0.
- out_* are registered or combinational from registered buffer/index only; no combinational path from out_ready to out_valid or out_data.

Test Plan:
- Basic drain: load pe_acc with element (r,c) = 10*r+c, pulse done, out_ready=1 → 16 beats 0,1,2,3,10,...,33 in row-major order; out_last only on 33; acc_clear and drain_done single pulses 1 cycle after beat 16; busy high for 17 cycles.
- Backpressure: toggle out_ready 1,0,0,1,... → no beat lost or duplicated; fields stable while out_ready=0; order unchanged.
- Saturation, SATURATE=1, OUT_W=16, ACC_W=20: inputs 40000, -40000, 32767, -32768, -1 → outputs 32767/sat, -32768/sat, 32767/0, -32768/0, -1/0. With SATURATE=0, 40000 → -25536, sat 0.
- Retrigger rules: done held high through the drain → exactly one drain. Done low 1 cycle then high during STREAM → ignored. Same toggle after drain_done → second drain containing the freshly captured data.
- Snapshot isolation: change pe_acc every cycle after capture → streamed values equal the capture-cycle values.
- Reset mid-stream: assert rst_n=0 at beat 7 → all outputs 0 immediately; no acc_clear or drain_done. After release, a new done rise drains from index 0.
